ahb_decoder_mux: RTL and testbench

AHB_DECODER_MUX -- requirements
Module: ahb_decoder_mux

---
 rtl/common_types_pkg.sv | 34 +++
 rtl/ahb_decoder_mux_if.sv | 50 +++++
 rtl/ahb_addr_decoder.sv | 29 ++
 rtl/ahb_decoder_mux.sv | 143 ++++++++++++++
 tb/tb_ahb_decoder_mux.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_types_pkg.sv
// Shared AHB-Lite types for the decoder/mux slice.
//   htrans_t     : AHB transfer type encoding
//   owner_t      : data-phase owner states of ahb_decoder_mux
//   ERR_CNT_W    : width of the decode-error counter
//   ERR_CNT_MAX  : saturation value of the decode-error counter
//   MAX_SAT      : largest supported satellite count
package common_types_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // NONE: zero-wait OKAY, SAT: a satellite owns the data phase,
    // ERR1/ERR2: the two cycles of the built-in default-slave ERROR response.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SAT  = 2'd1,
        OWN_ERR1 = 2'd2,
        OWN_ERR2 = 2'd3
    } owner_t;

    localparam int unsigned ERR_CNT_W           = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;
    localparam int unsigned MAX_SAT             = 16;

    // A transfer is active (needs a data phase) for NONSEQ and SEQ.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between one AHB-Lite controller and NUM_SAT satellites.
//   c_*            : controller side (address/control/write data in, read data/ready/resp out)
//   s_hsel         : per-satellite select
//   s_h* broadcast : controller address-phase signals forwarded to every satellite
//   s_hready       : HREADY fed back to all satellites
//   s_hreadyout/s_hresp/s_hrdata : per-satellite responses (s_hrdata flattened, sat i at [i*DATA_W +: DATA_W])
// Modports: slave = the decoder/mux's view, master = the environment driving it.
interface ahb_decoder_mux_if #(
    parameter int unsigned NUM_SAT = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);

    logic [ADDR_W-1:0]         c_haddr;
    logic [1:0]                c_htrans;
    logic                      c_hwrite;
    logic [2:0]                c_hsize;
    logic [2:0]                c_hburst;
    logic [DATA_W-1:0]         c_hwdata;
    logic [DATA_W-1:0]         c_hrdata;
    logic                      c_hready;
    logic                      c_hresp;

    logic [NUM_SAT-1:0]        s_hsel;
    logic [ADDR_W-1:0]         s_haddr;
    logic [1:0]                s_htrans;
    logic                      s_hwrite;
    logic [2:0]                s_hsize;
    logic [2:0]                s_hburst;
    logic [DATA_W-1:0]         s_hwdata;
    logic                      s_hready;
    logic [NUM_SAT-1:0]        s_hreadyout;
    logic [NUM_SAT-1:0]        s_hresp;
    logic [NUM_SAT*DATA_W-1:0] s_hrdata;

    modport slave (
        input  c_haddr, c_htrans, c_hwrite, c_hsize, c_hburst, c_hwdata,
        input  s_hreadyout, s_hresp, s_hrdata,
        output c_hrdata, c_hready, c_hresp,
        output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata, s_hready
    );

    modport master (
        output c_haddr, c_htrans, c_hwrite, c_hsize, c_hburst, c_hwdata,
        output s_hreadyout, s_hresp, s_hrdata,
        input  c_hrdata, c_hready, c_hresp,
        input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata, s_hready
    );

endinterface

// File: rtl/ahb_addr_decoder.sv
// Combinational base/mask address decoder.
//   addr_i    : address to decode
//   hit_c_o   : some satellite matches (addr_i & SAT_MASK[i]) == SAT_BASE[i]
//   idx_c_o   : lowest matching satellite index (0 when no hit)
module ahb_addr_decoder #(
    parameter int unsigned NUM_SAT = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter logic [NUM_SAT-1:0][ADDR_W-1:0] SAT_BASE = '0,
    parameter logic [NUM_SAT-1:0][ADDR_W-1:0] SAT_MASK = '0,
    parameter int unsigned IDX_W   = (NUM_SAT > 1) ? $clog2(NUM_SAT) : 1
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_c_o,
    output logic [IDX_W-1:0]  idx_c_o
);

    // Priority scan: first (lowest) match is kept, later overlaps are ignored.
    always_comb begin
        hit_c_o = 1'b0;
        idx_c_o = '0;
        for (int i = 0; i < int'(NUM_SAT); i++) begin
            if (!hit_c_o && ((addr_i & SAT_MASK[i]) == SAT_BASE[i])) begin
                hit_c_o = 1'b1;
                idx_c_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer with a built-in
// default slave that answers unmapped accesses with a two-cycle ERROR.
//   clk      : system clock
//   nrst     : asynchronous active-low reset
//   bus      : ahb_decoder_mux_if.slave (controller port, satellite ports)
//   err_cnt  : saturating count of decode errors (registered)
// Address-phase outputs (s_hsel, broadcasts) and the data-phase response
// mux (c_hready/c_hresp/c_hrdata, s_hready) are combinational by design.
module ahb_decoder_mux
    import common_types_pkg::*;
#(
    parameter int unsigned NUM_SAT = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter logic [NUM_SAT-1:0][ADDR_W-1:0] SAT_BASE = '0,
    parameter logic [NUM_SAT-1:0][ADDR_W-1:0] SAT_MASK = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    ahb_decoder_mux_if.slave      bus,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int unsigned IDX_W = (NUM_SAT > 1) ? $clog2(NUM_SAT) : 1;

    localparam logic [1:0] ST_NONE = 2'(OWN_NONE);
    localparam logic [1:0] ST_SAT  = 2'(OWN_SAT);
    localparam logic [1:0] ST_ERR1 = 2'(OWN_ERR1);
    localparam logic [1:0] ST_ERR2 = 2'(OWN_ERR2);

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 hit_c;
    logic [IDX_W-1:0]     hit_idx_c;
    logic                 active_c;
    logic                 hready_c;
    logic                 hresp_c;
    logic [DATA_W-1:0]    hrdata_c;
    logic [DATA_W-1:0]    sat_rdata [NUM_SAT];

    // Address decode of the current address phase.
    ahb_addr_decoder #(
        .NUM_SAT  (NUM_SAT),
        .ADDR_W   (ADDR_W),
        .SAT_BASE (SAT_BASE),
        .SAT_MASK (SAT_MASK),
        .IDX_W    (IDX_W)
    ) u_addr_decoder (
        .addr_i  (bus.c_haddr),
        .hit_c_o (hit_c),
        .idx_c_o (hit_idx_c)
    );

    assign active_c = htrans_active(bus.c_htrans);

    // Unflatten satellite read data for indexed selection.
    for (genvar g = 0; g < NUM_SAT; g++) begin : g_rdata
        assign sat_rdata[g] = bus.s_hrdata[g*DATA_W +: DATA_W];
    end

    // Address-phase select: only the winning hit, only for active transfers.
    always_comb begin
        bus.s_hsel = '0;
        if (active_c && hit_c) begin
            bus.s_hsel[hit_idx_c] = 1'b1;
        end
    end

    // Broadcast controller address/control/write data, unregistered.
    assign bus.s_haddr  = bus.c_haddr;
    assign bus.s_htrans = bus.c_htrans;
    assign bus.s_hwrite = bus.c_hwrite;
    assign bus.s_hsize  = bus.c_hsize;
    assign bus.s_hburst = bus.c_hburst;
    assign bus.s_hwdata = bus.c_hwdata;

    // Data-phase response mux and owner next-state.
    always_comb begin
        hready_c  = 1'b1;
        hresp_c   = 1'b0;
        hrdata_c  = '0;
        state_d   = state_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_SAT: begin
                hready_c = bus.s_hreadyout[idx_q];
                hresp_c  = bus.s_hresp[idx_q];
                hrdata_c = sat_rdata[idx_q];
            end
            ST_ERR1: begin
                hready_c = 1'b0;
                hresp_c  = 1'b1;
            end
            ST_ERR2: begin
                hresp_c  = 1'b1;
            end
            default: begin
            end
        endcase

        // ERR1 always stalls, so it advances to ERR2 without sampling a new
        // address phase; every other state samples one when HREADY is high.
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (hready_c) begin
            if (!active_c) begin
                state_d = ST_NONE;
            end else if (hit_c) begin
                state_d = ST_SAT;
                idx_d   = hit_idx_c;
            end else begin
                state_d = ST_ERR1;
                if (err_cnt_q != ERR_CNT_MAX) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    // Owner state, owner index and error counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_NONE;
            idx_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.c_hready = hready_c;
    assign bus.c_hresp  = hresp_c;
    assign bus.c_hrdata = hrdata_c;
    assign bus.s_hready = hready_c;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_ahb_decoder_mux;
    import common_types_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [NS-1:0][AW-1:0] M_BASE = {32'h4000_1000, 32'h4000_0000};
    localparam logic [NS-1:0][AW-1:0] M_MASK = {32'hFFFF_F000, 32'hFFFF_F000};
    localparam logic [NS-1:0][AW-1:0] O_BASE = {32'h4000_0000, 32'h4000_0000};
    localparam logic [NS-1:0][AW-1:0] O_MASK = {32'hFF00_0000, 32'hFFFF_F000};

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] m_err_cnt;
    logic [7:0] o_err_cnt;
    int         n_checks = 0;
    int         n_fail   = 0;

    ahb_decoder_mux_if #(.NUM_SAT(NS), .ADDR_W(AW), .DATA_W(DW)) m_if ();
    ahb_decoder_mux_if #(.NUM_SAT(NS), .ADDR_W(AW), .DATA_W(DW)) o_if ();

    ahb_decoder_mux #(
        .NUM_SAT(NS), .ADDR_W(AW), .DATA_W(DW), .SAT_BASE(M_BASE), .SAT_MASK(M_MASK)
    ) dut (
        .clk(clk), .nrst(nrst), .bus(m_if), .err_cnt(m_err_cnt)
    );

    ahb_decoder_mux #(
        .NUM_SAT(NS), .ADDR_W(AW), .DATA_W(DW), .SAT_BASE(O_BASE), .SAT_MASK(O_MASK)
    ) dut_ov (
        .clk(clk), .nrst(nrst), .bus(o_if), .err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode: first satellite in index order whose masked compare matches.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < int'(NS); i++) begin
            if ((a & M_MASK[i]) == M_BASE[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic w);
        m_if.c_htrans = tr;
        m_if.c_haddr  = a;
        m_if.c_hwrite = w;
        m_if.c_hsize  = 3'b010;
        m_if.c_hburst = 3'b000;
        m_if.c_hwdata = ~a;
    endtask

    task automatic set_sat(input int i, input logic rdy, input logic rsp, input logic [31:0] d);
        m_if.s_hreadyout[i]       = rdy;
        m_if.s_hresp[i]           = rsp;
        m_if.s_hrdata[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        drive(2'b00, 32'h0, 1'b0);
        set_sat(0, 1'b1, 1'b0, 32'h0);
        set_sat(1, 1'b1, 1'b0, 32'h0);
        o_if.c_htrans = 2'b00; o_if.c_haddr = 32'h0; o_if.c_hwrite = 1'b0;
        o_if.c_hsize = 3'b010; o_if.c_hburst = 3'b000; o_if.c_hwdata = 32'h0;
        o_if.s_hreadyout = 2'b11; o_if.s_hresp = 2'b00; o_if.s_hrdata = '0;
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_if.c_hrdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_resp: got rdy=%b resp=%b data=%h want 1 0 0",
                     m_if.c_hready, m_if.c_hresp, m_if.c_hrdata);
        end
        n_checks++;
        if (m_err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_cnt: got %0d want 0", m_err_cnt);
        end
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_stall_read();
        set_sat(0, 1'b1, 1'b0, 32'h0);
        drive(2'b10, 32'h4000_0004, 1'b0);
        @(negedge clk);
        n_checks++;
        if (m_if.s_hsel !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_hsel: got %b want 01", m_if.s_hsel);
        end
        n_checks++;
        if (m_if.s_haddr !== 32'h4000_0004) begin
            n_fail++;
            $display("FAIL stall_haddr_bcast: got %h want 40000004", m_if.s_haddr);
        end
        tick();
        drive(2'b00, 32'h0, 1'b0);
        set_sat(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({m_if.c_hready, m_if.s_hready} !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_wait%0d: got c_hready=%b s_hready=%b want 0 0",
                         k, m_if.c_hready, m_if.s_hready);
            end
            tick();
        end
        set_sat(0, 1'b1, 1'b0, 32'h1234_5678);
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_if.c_hrdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL stall_data: got rdy=%b resp=%b data=%h want 1 0 12345678",
                     m_if.c_hready, m_if.c_hresp, m_if.c_hrdata);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_if.c_hrdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL stall_idle_after: got rdy=%b resp=%b data=%h want 1 0 0",
                     m_if.c_hready, m_if.c_hresp, m_if.c_hrdata);
        end
        tick();
    endtask

    task automatic test_unmapped();
        drive(2'b10, 32'h5000_0000, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({m_if.s_hsel, m_if.s_hwrite, m_if.s_hwdata} !== {2'b00, 1'b1, 32'hAFFF_FFFF}) begin
            n_fail++;
            $display("FAIL unmapped_addr_phase: got hsel=%b hwrite=%b hwdata=%h want 00 1 afffffff",
                     m_if.s_hsel, m_if.s_hwrite, m_if.s_hwdata);
        end
        tick();
        drive(2'b00, 32'h0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_if.c_hrdata, m_err_cnt} !== {1'b0, 1'b1, 32'h0, 8'd1}) begin
            n_fail++;
            $display("FAIL unmapped_err1: got rdy=%b resp=%b data=%h cnt=%0d want 0 1 0 1",
                     m_if.c_hready, m_if.c_hresp, m_if.c_hrdata, m_err_cnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_if.c_hrdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL unmapped_err2: got rdy=%b resp=%b data=%h want 1 1 0",
                     m_if.c_hready, m_if.c_hresp, m_if.c_hrdata);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL unmapped_after: got rdy=%b resp=%b cnt=%0d want 1 0 1",
                     m_if.c_hready, m_if.c_hresp, m_err_cnt);
        end
        tick();
    endtask

    task automatic test_overlap();
        logic [31:0] oa [6];
        logic [1:0]  ot [6];
        logic [1:0]  oe [6];
        oa[0] = 32'h4000_0000; ot[0] = 2'b10; oe[0] = 2'b01;
        oa[1] = 32'h4012_3000; ot[1] = 2'b10; oe[1] = 2'b10;
        oa[2] = 32'h4000_0FFC; ot[2] = 2'b11; oe[2] = 2'b01;
        oa[3] = 32'h4000_0000; ot[3] = 2'b01; oe[3] = 2'b00;
        oa[4] = 32'h6000_0000; ot[4] = 2'b10; oe[4] = 2'b00;
        oa[5] = 32'h4000_0000; ot[5] = 2'b00; oe[5] = 2'b00;
        for (int k = 0; k < 6; k++) begin
            o_if.c_haddr  = oa[k];
            o_if.c_htrans = ot[k];
            @(negedge clk);
            n_checks++;
            if (o_if.s_hsel !== oe[k]) begin
                n_fail++;
                $display("FAIL overlap_hsel%0d: addr=%h got %b want %b", k, oa[k], o_if.s_hsel, oe[k]);
            end
            tick();
        end
        n_checks++;
        if (o_err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL overlap_err_cnt: got %0d want 1", o_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        set_sat(0, 1'b1, 1'b0, 32'hAAAA_0000);
        set_sat(1, 1'b1, 1'b0, 32'hBBBB_1111);
        drive(2'b10, 32'h4000_0010, 1'b0);
        @(negedge clk);
        n_checks++;
        if (m_if.s_hsel !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_hsel0: got %b want 01", m_if.s_hsel);
        end
        tick();
        drive(2'b10, 32'h4000_1020, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({m_if.s_hsel, m_if.c_hready, m_if.c_hrdata} !== {2'b10, 1'b1, 32'hAAAA_0000}) begin
            n_fail++;
            $display("FAIL b2b_sat0_data: got hsel=%b rdy=%b data=%h want 10 1 aaaa0000",
                     m_if.s_hsel, m_if.c_hready, m_if.c_hrdata);
        end
        tick();
        drive(2'b00, 32'h0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hrdata} !== {1'b1, 32'hBBBB_1111}) begin
            n_fail++;
            $display("FAIL b2b_sat1_data: got rdy=%b data=%h want 1 bbbb1111",
                     m_if.c_hready, m_if.c_hrdata);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (m_if.c_hrdata !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_idle_data: got %h want 0", m_if.c_hrdata);
        end
        tick();
    endtask

    task automatic test_reset_in_err();
        drive(2'b10, 32'h5000_0000, 1'b0);
        tick();
        drive(2'b00, 32'h0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_err_cnt} !== {1'b0, 1'b1, 8'd2}) begin
            n_fail++;
            $display("FAIL rst_err_pre: got rdy=%b resp=%b cnt=%0d want 0 1 2",
                     m_if.c_hready, m_if.c_hresp, m_err_cnt);
        end
        #1;
        nrst = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({m_if.c_hready, m_if.c_hresp, m_if.c_hrdata, m_err_cnt} !== {1'b1, 1'b0, 32'h0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_err_post: got rdy=%b resp=%b data=%h cnt=%0d want 1 0 0 0",
                     m_if.c_hready, m_if.c_hresp, m_if.c_hrdata, m_err_cnt);
        end
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_err_saturate();
        int edges;
        edges = 0;
        drive(2'b10, 32'h5000_0000, 1'b1);
        // Each unmapped transfer costs two edges, so after n edges the count is ceil(n/2).
        while (edges < 600) begin
            tick();
            edges++;
            if (edges == 20 || edges == 508 || edges == 510 || edges == 600) begin
                @(negedge clk);
                n_checks++;
                if (m_err_cnt !== 8'((edges + 1) / 2 > 255 ? 255 : (edges + 1) / 2)) begin
                    n_fail++;
                    $display("FAIL err_sat_%0d: got %0d want %0d", edges, m_err_cnt,
                             ((edges + 1) / 2 > 255) ? 255 : (edges + 1) / 2);
                end
            end
        end
        drive(2'b00, 32'h0, 1'b0);
        tick(); tick();
    endtask

    task automatic test_random();
        int          mk, mi, mstep, mcnt, d;
        logic        hold, eh, er;
        logic [31:0] ed, a;
        logic [1:0]  tr, esel;
        logic [1:0]  s_rdy, s_rsp;
        logic [31:0] s_dat [2];
        nrst = 1'b0;
        drive(2'b00, 32'h0, 1'b0);
        tick();
        nrst = 1'b1;
        tick();
        mk = 0; mi = 0; mstep = 0; mcnt = 0; hold = 1'b0;
        tr = 2'b00; a = 32'h0;
        for (int c = 0; c < 500; c++) begin
            if (!hold) begin
                tr = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 2))
                    0:       a = 32'h4000_0000 | ($urandom & 32'h0000_0FFC);
                    1:       a = 32'h4000_1000 | ($urandom & 32'h0000_0FFC);
                    default: a = {4'h5, 28'($urandom)};
                endcase
                drive(tr, a, 1'($urandom));
            end
            for (int i = 0; i < 2; i++) begin
                s_rdy[i] = ($urandom_range(0, 3) != 0);
                s_rsp[i] = ($urandom_range(0, 7) == 0);
                s_dat[i] = $urandom;
                set_sat(i, s_rdy[i], s_rsp[i], s_dat[i]);
            end
            @(negedge clk);
            case (mk)
                1:       begin eh = s_rdy[mi]; er = s_rsp[mi]; ed = s_dat[mi]; end
                2:       begin eh = (mstep == 1); er = 1'b1; ed = 32'h0; end
                default: begin eh = 1'b1; er = 1'b0; ed = 32'h0; end
            endcase
            d = ref_decode(a);
            esel = 2'b00;
            if (tr[1] && d >= 0) esel[d] = 1'b1;
            n_checks++;
            if ({m_if.c_hready, m_if.s_hready, m_if.c_hresp, m_if.c_hrdata} !== {eh, eh, er, ed}) begin
                n_fail++;
                $display("FAIL rand_resp c%0d: got rdy=%b srdy=%b resp=%b data=%h want %b %b %b %h",
                         c, m_if.c_hready, m_if.s_hready, m_if.c_hresp, m_if.c_hrdata, eh, eh, er, ed);
            end
            n_checks++;
            if ({m_if.s_hsel, m_if.s_haddr, m_if.s_htrans} !== {esel, a, tr}) begin
                n_fail++;
                $display("FAIL rand_addr c%0d: got hsel=%b haddr=%h htrans=%b want %b %h %b",
                         c, m_if.s_hsel, m_if.s_haddr, m_if.s_htrans, esel, a, tr);
            end
            n_checks++;
            if (m_err_cnt !== 8'((mcnt > 255) ? 255 : mcnt)) begin
                n_fail++;
                $display("FAIL rand_err_cnt c%0d: got %0d want %0d", c, m_err_cnt, mcnt);
            end
            // Advance the reference to the next clock edge.
            if (mk == 2 && mstep == 0) begin
                mstep = 1;
            end else if (eh) begin
                if (!tr[1]) begin
                    mk = 0;
                end else if (d >= 0) begin
                    mk = 1; mi = d;
                end else begin
                    mk = 2; mstep = 0; mcnt++;
                end
            end
            hold = !eh;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stall_read();
        test_unmapped();
        test_overlap();
        test_back_to_back();
        test_reset_in_err();
        test_err_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
